// File: rtl/j1x_core.sv
// j1x_core: parametrised J1 dual-stack CPU with a stalling data-read handshake,
// one maskable interrupt and sticky data/return stack fault flags.
module j1x_core #(
  parameter int WIDTH      = 32,
  parameter int DDEPTH     = 32,
  parameter int RDEPTH     = 32,
  parameter int CAW        = 13,
  parameter int IRQ_VECTOR = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CAW-1:0]   code_addr,
  input  logic [15:0]      insn,
  output logic [15:0]      mem_addr,
  output logic [WIDTH-1:0] dout,
  output logic             mem_wr,
  output logic             mem_rd,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_din,
  output logic             io_wr,
  input  logic [WIDTH-1:0] io_din,
  input  logic             irq,
  output logic             ie,
  output logic [1:0]       dfault,
  output logic [1:0]       rfault
);
  localparam int DPW = $clog2(DDEPTH);
  localparam int RPW = $clog2(RDEPTH);
  localparam int SW  = $clog2(WIDTH);
  localparam logic [CAW-1:0] IRQ_PC = CAW'(IRQ_VECTOR);

  typedef enum logic [3:0] {
    OP_T, OP_N, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_INV, OP_EQ,
    OP_SLT, OP_SHR, OP_SHL, OP_R, OP_MEM, OP_IO, OP_DEPTH, OP_ULT
  } alu_op_e;

  logic [CAW-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [DPW-1:0]   dsp_q, dsp_d;
  logic [RPW-1:0]   rsp_q, rsp_d;
  logic             ie_q, ie_d;
  logic [1:0]       dfault_q, dfault_d;
  logic [1:0]       rfault_q, rfault_d;
  logic             reboot_q;

  logic [WIDTH-1:0] dstack_q [DDEPTH];
  logic [WIDTH-1:0] rstack_q [RDEPTH];

  logic [WIDTH-1:0] n, r, alu, r_wd;
  logic [CAW-1:0]   pc_inc, jmp_pc;
  logic [DPW+1:0]   dsum;
  logic [RPW+1:0]   rsum;
  logic [1:0]       d_delta, r_delta;
  logic [2:0]       func;
  logic             is_alu, rd_req, stall, take_irq, exec;
  logic             d_we, r_we;
  alu_op_e          op;

  assign n      = dstack_q[dsp_q];
  assign r      = rstack_q[rsp_q];
  assign op     = alu_op_e'(insn[11:8]);
  assign func   = insn[6:4];
  assign is_alu = (insn[15:13] == 3'b011);
  assign pc_inc = pc_q + CAW'(1);
  assign jmp_pc = CAW'(insn[12:0]);

  // A read in flight is never interrupted: the irq waits for it to finish.
  assign rd_req   = !reboot_q && is_alu && (op == OP_MEM);
  assign stall    = rd_req && !mem_ready;
  assign take_irq = irq && ie_q && !reboot_q && !rd_req;
  assign exec     = !reboot_q && !stall && !take_irq;

  always_comb begin
    alu = '0;
    case (op)
      OP_T:     alu = t_q;
      OP_N:     alu = n;
      OP_ADD:   alu = t_q + n;
      OP_AND:   alu = t_q & n;
      OP_OR:    alu = t_q | n;
      OP_XOR:   alu = t_q ^ n;
      OP_INV:   alu = ~t_q;
      OP_EQ:    alu = {WIDTH{n == t_q}};
      OP_SLT:   alu = {WIDTH{$signed(n) < $signed(t_q)}};
      OP_SHR:   alu = n >> t_q[SW-1:0];
      OP_SHL:   alu = n << t_q[SW-1:0];
      OP_R:     alu = r;
      OP_MEM:   alu = mem_din;
      OP_IO:    alu = io_din;
      OP_DEPTH: alu[RPW+DPW-1:0] = {rsp_q, dsp_q};
      OP_ULT:   alu = {WIDTH{n < t_q}};
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    t_d     = t_q;
    ie_d    = ie_q;
    d_delta = 2'b00;
    r_delta = 2'b00;
    d_we    = 1'b0;
    r_we    = 1'b0;
    r_wd    = t_q;
    if (reboot_q) begin
      pc_d = '0;
    end else if (take_irq) begin
      // Discard the fetched insn; returning to pc re-executes it.
      pc_d       = IRQ_PC;
      ie_d       = 1'b0;
      r_delta    = 2'b01;
      r_we       = 1'b1;
      r_wd       = '0;
      r_wd[CAW:1] = pc_q;
    end else if (!stall) begin
      pc_d = pc_inc;
      if (insn[15]) begin
        t_d     = {{(WIDTH-15){1'b0}}, insn[14:0]};
        d_delta = 2'b01;
        d_we    = 1'b1;
      end else begin
        case (insn[14:13])
          2'b00: pc_d = jmp_pc;
          2'b01: begin
            d_delta = 2'b11;
            t_d     = n;
            if (t_q == '0) pc_d = jmp_pc;
          end
          2'b10: begin
            r_delta     = 2'b01;
            r_we        = 1'b1;
            r_wd        = '0;
            r_wd[CAW:1] = pc_inc;
            pc_d        = jmp_pc;
          end
          default: begin
            t_d     = alu;
            d_delta = insn[1:0];
            r_delta = insn[3:2];
            if (insn[7]) pc_d = r[CAW:1];
            d_we = (func == 3'd1);
            r_we = (func == 3'd2);
            if (func == 3'd5) ie_d = t_q[0];
          end
        endcase
      end
    end
    // Pointers wrap; the extra top bit of the sum flags a negative result.
    dsum     = {2'b00, dsp_q} + {{DPW{d_delta[1]}}, d_delta};
    rsum     = {2'b00, rsp_q} + {{RPW{r_delta[1]}}, r_delta};
    dsp_d    = dsum[DPW-1:0];
    rsp_d    = rsum[RPW-1:0];
    dfault_d = dfault_q | {(d_delta == 2'b01) && (dsp_q == '1), dsum[DPW+1]};
    rfault_d = rfault_q | {(r_delta == 2'b01) && (rsp_q == '1), rsum[RPW+1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      t_q      <= '0;
      dsp_q    <= '0;
      rsp_q    <= '0;
      ie_q     <= 1'b0;
      dfault_q <= 2'b00;
      rfault_q <= 2'b00;
      reboot_q <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      t_q      <= t_d;
      dsp_q    <= dsp_d;
      rsp_q    <= rsp_d;
      ie_q     <= ie_d;
      dfault_q <= dfault_d;
      rfault_q <= rfault_d;
      reboot_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (d_we) dstack_q[dsp_d] <= t_q;
    if (r_we) rstack_q[rsp_d] <= r_wd;
  end

  assign code_addr = pc_d;
  assign mem_addr  = t_q[15:0];
  assign dout      = n;
  assign mem_rd    = rd_req;
  assign mem_wr    = exec && is_alu && (func == 3'd3);
  assign io_wr     = exec && is_alu && (func == 3'd4);
  assign ie        = ie_q;
  assign dfault    = dfault_q;
  assign rfault    = rfault_q;
endmodule

// File: tb/tb_j1x_core.sv
// Directed bench for j1x_core: small programs in a registered code RAM,
// hand-computed expected stack/pc/flag values checked after each step.
module tb_j1x_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] code_addr;
  logic [15:0] insn;
  logic [15:0] mem_addr;
  logic [31:0] dout;
  logic        mem_wr, mem_rd, mem_ready, io_wr, irq, ie;
  logic [31:0] mem_din, io_din;
  logic [1:0]  dfault, rfault;

  logic [15:0] code_mem [0:8191];
  int tests = 0;
  int fails = 0;

  j1x_core #(.WIDTH(32), .DDEPTH(4), .RDEPTH(8), .CAW(13), .IRQ_VECTOR(32)) dut (
    .clk(clk), .reset(reset), .code_addr(code_addr), .insn(insn),
    .mem_addr(mem_addr), .dout(dout), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_din(mem_din), .io_wr(io_wr), .io_din(io_din),
    .irq(irq), .ie(ie), .dfault(dfault), .rfault(rfault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) insn <= code_mem[code_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reset, run the reboot cycle; returns with pc = 0 and insn[0] presented.
  task automatic boot();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1; irq = 1'b0; mem_ready = 1'b1; mem_din = '0; io_din = 32'h0000_1111;
    for (int i = 0; i < 8192; i++) code_mem[i] = 16'h0000;

    // lit 0x1234, lit 1, '+' with D delta -1
    code_mem[0] = 16'h9234; code_mem[1] = 16'h8001; code_mem[2] = 16'h6203; code_mem[3] = 16'h0003;
    step(2);
    chk("rst_pc", 32'(dut.pc_q), 32'h0);
    chk("rst_t", 32'(dut.t_q), 32'h0);
    chk("rst_dsp", 32'(dut.dsp_q), 32'h0);
    chk("rst_rsp", 32'(dut.rsp_q), 32'h0);
    chk("rst_flags", 32'({ie, dfault, rfault}), 32'h0);
    reset = 1'b0;
    #1;
    chk("reboot_strobes", 32'({mem_wr, mem_rd, io_wr}), 32'h0);
    chk("reboot_code_addr", 32'(code_addr), 32'h0);
    step(1);
    step(3);
    chk("add_t", dut.t_q, 32'h0000_1235);
    chk("add_dsp", 32'(dut.dsp_q), 32'h1);
    chk("add_n", dout, 32'h0);

    // shift / signed / unsigned compare with N = 0x80000000, T = 1
    code_mem[0] = 16'h8001; code_mem[1] = 16'h801F; code_mem[2] = 16'h6A03;
    code_mem[3] = 16'h8001; code_mem[4] = 16'h6811; code_mem[5] = 16'h6103;
    code_mem[6] = 16'h6F00; code_mem[7] = 16'h0007;
    boot();
    step(3);
    chk("shl31", dut.t_q, 32'h8000_0000);
    step(2);
    chk("slt", dut.t_q, 32'hFFFF_FFFF);
    step(2);
    chk("ult", dut.t_q, 32'h0);
    chk("ult_dsp", 32'(dut.dsp_q), 32'h2);
    chk("cmp_dfault", 32'(dfault), 32'h0);

    // memory read stalled for 3 cycles
    code_mem[0] = 16'h8010; code_mem[1] = 16'h6C00; code_mem[2] = 16'h0002;
    mem_ready = 1'b0;
    boot();
    step(1);
    chk("rd_req", 32'(mem_rd), 32'h1);
    chk("rd_addr", 32'(mem_addr), 32'h10);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("stall_code_addr", 32'(code_addr), 32'h1);
      chk("stall_t", dut.t_q, 32'h10);
      chk("stall_ptrs", 32'({dut.dsp_q, dut.rsp_q}), 32'(5'b01_000));
      chk("stall_strobes", 32'({mem_rd, mem_wr, io_wr}), 32'b100);
    end
    mem_din = 32'h0000_CAFE; mem_ready = 1'b1;
    #1;
    chk("rd_done_code_addr", 32'(code_addr), 32'h2);
    step(1);
    chk("rd_t", dut.t_q, 32'h0000_CAFE);
    chk("rd_pc", 32'(dut.pc_q), 32'h2);
    chk("rd_dsp", 32'(dut.dsp_q), 32'h1);

    // interrupt during a jump at 0x40, handler at 0x20
    code_mem[0] = 16'h8001; code_mem[1] = 16'h6153; code_mem[2] = 16'h0040;
    code_mem[16'h40] = 16'h0041; code_mem[16'h41] = 16'h0041;
    code_mem[16'h20] = 16'h6B01; code_mem[16'h21] = 16'h6103; code_mem[16'h22] = 16'h608C;
    boot();
    step(2);
    chk("ie_set", 32'(ie), 32'h1);
    step(1);
    chk("at_0x40", 32'(dut.pc_q), 32'h40);
    irq = 1'b1;
    #1;
    chk("irq_code_addr", 32'(code_addr), 32'h20);
    step(1);
    chk("irq_pc", 32'(dut.pc_q), 32'h20);
    chk("irq_ie", 32'(ie), 32'h0);
    chk("irq_rsp", 32'(dut.rsp_q), 32'h1);
    step(1);
    chk("irq_rtop", 32'(mem_addr), 32'h80);
    step(2);
    chk("ret_pc", 32'(dut.pc_q), 32'h40);
    chk("ret_rsp", 32'(dut.rsp_q), 32'h0);
    step(1);
    chk("reexec_jump", 32'(dut.pc_q), 32'h41);
    chk("irq_rfault", 32'(rfault), 32'h0);
    irq = 1'b0;

    // data stack overflow: 4 literals into a 4-deep stack
    code_mem[0] = 16'h8001; code_mem[1] = 16'h8002; code_mem[2] = 16'h8003;
    code_mem[3] = 16'h8004; code_mem[4] = 16'h0004;
    boot();
    step(3);
    chk("pre_ovf", 32'(dfault), 32'h0);
    step(1);
    chk("ovf_flag", 32'(dfault), 32'b10);
    chk("ovf_dsp", 32'(dut.dsp_q), 32'h0);
    chk("ovf_n", dout, 32'h3);
    step(3);
    chk("ovf_sticky", 32'(dfault), 32'b10);

    // underflow: one drop from reset
    code_mem[0] = 16'h6103; code_mem[1] = 16'h0001;
    reset = 1'b1;
    step(2);
    chk("rst_clears_fault", 32'(dfault), 32'h0);
    reset = 1'b0;
    step(1);
    step(1);
    chk("unf_flag", 32'(dfault), 32'b01);
    chk("unf_dsp", 32'(dut.dsp_q), 32'h3);
    step(3);
    chk("unf_sticky", 32'(dfault), 32'b01);

    // reset during a read stall; read also does T->N (dstack[0] holds 3)
    code_mem[0] = 16'h6C10; code_mem[1] = 16'h0001;
    mem_ready = 1'b0;
    boot();
    chk("s6_rd_req", 32'(mem_rd), 32'h1);
    step(2);
    chk("s6_stall_pc", 32'(dut.pc_q), 32'h0);
    chk("s6_stall_n", dout, 32'h3);
    reset = 1'b1;
    #1;
    chk("s6_rst_rd", 32'(mem_rd), 32'h0);
    chk("s6_rst_pc", 32'(code_addr), 32'h0);
    step(1);
    reset = 1'b0;
    #1;
    chk("s6_reboot_rd", 32'(mem_rd), 32'h0);
    step(1);
    chk("s6_no_write", dout, 32'h3);
    chk("s6_dsp", 32'(dut.dsp_q), 32'h0);
    chk("s6_rd_again", 32'(mem_rd), 32'h1);
    mem_din = 32'h0000_0077; mem_ready = 1'b1;
    step(1);
    chk("s6_rd_t", 32'(mem_addr), 32'h77);
    chk("s6_rd_tn", dout, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
